spram_arb: RTL

SPRAM_ARB -- requirements
Module: spram_arb

---
 rtl/spram_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/spram_arb.sv
// spram_arb: arbitrates one single-port RAM between a queued pixel-write
// stream and a display read stream. Reads win until a pending write has
// waited STARVE_MAX read grants, then one write is forced through.
// Optional build macro SPRAM_ARB_STATS_EN adds a 16-bit write-stall counter
// output (o_stall_cnt).
module spram_arb #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 12,
  parameter int unsigned WQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                        i_clk_sys,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [DW-1:0]               i_wr_data,
  input  logic                        i_rd_req,
  input  logic [AW-1:0]               i_rd_addr,
  output logic                        o_rd_gnt,
  output logic                        o_rd_valid,
  output logic [DW-1:0]               o_rd_data,
  output logic                        o_ram_ce,
  output logic                        o_ram_wre,
  output logic [AW-1:0]               o_ram_ad,
  output logic [DW-1:0]               o_ram_din,
  input  logic [DW-1:0]               i_ram_dout,
  output logic [$clog2(WQ_DEPTH):0]   o_wq_level
`ifdef SPRAM_ARB_STATS_EN
  ,
  output logic [15:0]                 o_stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(WQ_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] WQ_FULL    = LW'(WQ_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE
  } acc_e;

  acc_e          acc;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level;
  logic [SW-1:0] starve_q, starve_d;
  logic          rd_valid_q, rd_valid_d;
  logic [AW-1:0] wq_addr_q [WQ_DEPTH];
  logic [AW-1:0] wq_addr_d [WQ_DEPTH];
  logic [DW-1:0] wq_data_q [WQ_DEPTH];
  logic [DW-1:0] wq_data_d [WQ_DEPTH];
  logic          empty;
  logic          push;

  // Queue occupancy and write-side handshake (pointers carry one wrap bit).
  always_comb begin
    level      = wr_ptr_q - rd_ptr_q;
    empty      = (level == '0);
    o_wr_ready = (level < WQ_FULL) && !i_flush;
    push       = i_wr_valid && o_wr_ready;
  end

  // Access arbitration from registered queue state; drives the RAM port.
  always_comb begin
    acc = ACC_IDLE;
    if (i_rd_req && (empty || (starve_q < STARVE_LIM))) begin
      acc = ACC_READ;
    end else if (!empty && !i_flush) begin
      // Reaching here with a read pending implies starve_q == STARVE_LIM.
      acc = ACC_WRITE;
    end
    o_rd_gnt  = (acc == ACC_READ);
    o_ram_ce  = (acc != ACC_IDLE);
    o_ram_wre = (acc == ACC_WRITE);
    o_ram_ad  = (acc == ACC_WRITE) ? wq_addr_q[rd_ptr_q[PW-1:0]] : i_rd_addr;
    o_ram_din = wq_data_q[rd_ptr_q[PW-1:0]];
  end

  // Next-state for queue pointers, storage and the starvation counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    starve_d   = starve_q;
    wq_addr_d  = wq_addr_q;
    wq_data_d  = wq_data_q;
    rd_valid_d = o_rd_gnt;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      starve_d = '0;
    end else begin
      if (push) begin
        wq_addr_d[wr_ptr_q[PW-1:0]] = i_wr_addr;
        wq_data_d[wr_ptr_q[PW-1:0]] = i_wr_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (acc == ACC_WRITE) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if ((acc == ACC_WRITE) || empty) begin
        starve_d = '0;
      end else if ((acc == ACC_READ) && (starve_q < STARVE_LIM)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Queue payload storage; contents are only meaningful behind the pointers.
  always_ff @(posedge i_clk_sys) begin
    wq_addr_q <= wq_addr_d;
    wq_data_q <= wq_data_d;
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = i_ram_dout;
  assign o_wq_level = level;

`ifdef SPRAM_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles a write was offered but refused.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_flush) begin
      stall_cnt_d = '0;
    end else if (i_wr_valid && !o_wr_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
